// File: rtl/og_fft_pkg.sv
// Shared types and constants for the fixed-coefficient 8-point FFT.
// The rounding helper is the only arithmetic shared between the butterfly and the top.
package og_fft_pkg;
    localparam int N     = 8;
    localparam int OUT_W = 9;
    localparam int INT_W = 12;
    localparam int TW_Q8 = 181;
    localparam int FRAC  = 8;

    typedef struct packed {
        logic signed [INT_W-1:0] re;
        logic signed [INT_W-1:0] im;
    } cplx_t;

    // Stage-1 input order for decimation in time.
    localparam int BITREV [N] = '{0, 4, 2, 6, 1, 5, 3, 7};

    // Scale by the twiddle magnitude, rounding half up; the shift is arithmetic.
    function automatic logic signed [INT_W-1:0] tw_scale(input logic signed [INT_W-1:0] v,
                                                         input int tw, input int frac);
        logic signed [31:0] p;
        p = 32'(v) * tw + (32'sd1 <<< (frac - 1));
        return INT_W'(p >>> frac);
    endfunction

    function automatic logic signed [OUT_W-1:0] to_out(input logic signed [INT_W-1:0] v);
        return v[OUT_W-1:0];
    endfunction
endpackage

// File: rtl/og_fft_bfly.sv
// Radix-2 butterfly: o_p = a + W^tw * b, o_m = a - W^tw * b, where W = exp(-j*pi/4).
// W^1 and W^3 use the exact (+-1-j) product and then scale each component.
module og_fft_bfly
    import og_fft_pkg::*;
#(
    parameter int P_TW   = TW_Q8,
    parameter int P_FRAC = FRAC
) (
    input  cplx_t      i_a,
    input  cplx_t      i_b,
    input  logic [1:0] i_tw,
    output cplx_t      o_p,
    output cplx_t      o_m
);
    cplx_t w_t;

    always_comb begin
        w_t = i_b;
        case (i_tw)
            2'd0: w_t = i_b;
            2'd1: begin
                w_t.re = tw_scale(i_b.re + i_b.im, P_TW, P_FRAC);
                w_t.im = tw_scale(i_b.im - i_b.re, P_TW, P_FRAC);
            end
            2'd2: begin
                w_t.re = i_b.im;
                w_t.im = -i_b.re;
            end
            2'd3: begin
                w_t.re = tw_scale(i_b.im - i_b.re, P_TW, P_FRAC);
                w_t.im = tw_scale(-i_b.re - i_b.im, P_TW, P_FRAC);
            end
            default: w_t = i_b;
        endcase
    end

    assign o_p.re = i_a.re + w_t.re;
    assign o_p.im = i_a.im + w_t.im;
    assign o_m.re = i_a.re - w_t.re;
    assign o_m.im = i_a.im - w_t.im;
endmodule

// File: rtl/og_fft8.sv
// 8-point DIT FFT of constant real samples; one bin, chosen by sel, is registered out.
// The whole transform is combinational from parameters; only the output holds state.
module og_fft8 #(
    parameter int X0   = 1,
    parameter int X1   = 2,
    parameter int X2   = 3,
    parameter int X3   = 4,
    parameter int X4   = 5,
    parameter int X5   = 6,
    parameter int X6   = 7,
    parameter int X7   = 8,
    parameter int TW   = 181,
    parameter int FRAC = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic        [2:0] sel,
    output logic signed [8:0] yr,
    output logic signed [8:0] yi
);
    import og_fft_pkg::*;

    localparam int XS [N] = '{X0, X1, X2, X3, X4, X5, X6, X7};

    cplx_t w_x  [N];
    cplx_t w_s1 [N];
    cplx_t w_s2 [N];
    cplx_t w_y  [N];

    for (genvar i = 0; i < N; i++) begin : g_in
        assign w_x[i].re = INT_W'(XS[i]);
        assign w_x[i].im = '0;
    end

    // Stage 1 yields a0,a1,b0,b1,c0,c1,d0,d1; stage 2 yields E0..E3,O0..O3.
    for (genvar g = 0; g < 4; g++) begin : g_st1
        og_fft_bfly #(.P_TW(TW), .P_FRAC(FRAC)) u_bf (
            .i_a (w_x[BITREV[2*g]]),
            .i_b (w_x[BITREV[2*g+1]]),
            .i_tw(2'd0),
            .o_p (w_s1[2*g]),
            .o_m (w_s1[2*g+1])
        );
    end

    for (genvar h = 0; h < 2; h++) begin : g_st2
        for (genvar j = 0; j < 2; j++) begin : g_pair
            og_fft_bfly #(.P_TW(TW), .P_FRAC(FRAC)) u_bf (
                .i_a (w_s1[4*h+j]),
                .i_b (w_s1[4*h+j+2]),
                .i_tw(2'(2*j)),
                .o_p (w_s2[4*h+j]),
                .o_m (w_s2[4*h+j+2])
            );
        end
    end

    for (genvar k = 0; k < 4; k++) begin : g_st3
        og_fft_bfly #(.P_TW(TW), .P_FRAC(FRAC)) u_bf (
            .i_a (w_s2[k]),
            .i_b (w_s2[k+4]),
            .i_tw(2'(k)),
            .o_p (w_y[k]),
            .o_m (w_y[k+4])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            yr <= '0;
            yi <= '0;
        end else begin
            yr <= to_out(w_y[sel].re);
            yi <= to_out(w_y[sel].im);
        end
    end
endmodule

// File: tb/tb_og_fft8.sv
// Bench for og_fft8: four parameter sets driven by one sel/rst, checked against a DFT-based model.
module tb_og_fft8;
    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic        [2:0] sel = 3'd0;
    logic signed [8:0] yr [4];
    logic signed [8:0] yi [4];

    int n_assert = 0;
    int n_fail   = 0;
    int smp [4][8];

    always #5 clk = ~clk;

    og_fft8 u_def (.clk(clk), .rst(rst), .sel(sel), .yr(yr[0]), .yi(yi[0]));
    og_fft8 #(.X0(15), .X1(0), .X2(0), .X3(0), .X4(0), .X5(0), .X6(0), .X7(0))
        u_imp (.clk(clk), .rst(rst), .sel(sel), .yr(yr[1]), .yi(yi[1]));
    og_fft8 #(.X0(-16), .X1(-16), .X2(-16), .X3(-16), .X4(-16), .X5(-16), .X6(-16), .X7(-16))
        u_ext (.clk(clk), .rst(rst), .sel(sel), .yr(yr[2]), .yi(yi[2]));
    og_fft8 #(.X0(-7), .X1(13), .X2(-16), .X3(15), .X4(4), .X5(-9), .X6(0), .X7(11))
        u_mix (.clk(clk), .rst(rst), .sel(sel), .yr(yr[3]), .yi(yi[3]));

    function automatic int rnd(input int v);
        return int'($floor((real'(v) * 181.0 + 128.0) / 256.0));
    endfunction

    // X[k] = E[k mod 4] +- W^k * O[k mod 4], with E/O as exact 4-point DFTs of even/odd samples.
    function automatic void ref_bin(input int x[8], input int k, output int re, output int im);
        int er, ei, orr, oi, tr, ti, k4, m;
        k4 = k % 4;
        er = 0; ei = 0; orr = 0; oi = 0;
        for (int n = 0; n < 4; n++) begin
            m = (n * k4) % 4;
            case (m)
                0: begin er += x[2*n]; orr += x[2*n+1]; end
                1: begin ei -= x[2*n]; oi  -= x[2*n+1]; end
                2: begin er -= x[2*n]; orr -= x[2*n+1]; end
                default: begin ei += x[2*n]; oi += x[2*n+1]; end
            endcase
        end
        case (k4)
            0: begin tr = orr; ti = oi; end
            1: begin tr = rnd(orr + oi); ti = rnd(oi - orr); end
            2: begin tr = oi; ti = -orr; end
            default: begin tr = rnd(oi - orr); ti = rnd(-orr - oi); end
        endcase
        if (k < 4) begin re = er + tr; im = ei + ti; end
        else       begin re = er - tr; im = ei - ti; end
    endfunction

    task automatic chk(input string tag, input int obs, input int exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Drive one cycle, then compare every instance against the model.
    task automatic cycle(input logic r, input logic [2:0] s);
        int er, ei;
        rst = r;
        sel = s;
        @(posedge clk);
        #1;
        for (int d = 0; d < 4; d++) begin
            if (r) begin er = 0; ei = 0; end
            else ref_bin(smp[d], int'(s), er, ei);
            chk($sformatf("model d%0d sel%0d rst%0d re", d, s, r), int'(yr[d]), er);
            chk($sformatf("model d%0d sel%0d rst%0d im", d, s, r), int'(yi[d]), ei);
        end
    endtask

    int exp_re [8] = '{36, -4, -4, -4, -4, -4, -4, -4};
    int exp_im [8] = '{0, 10, 4, 2, 0, -2, -4, -10};

    initial begin
        smp[0] = '{1, 2, 3, 4, 5, 6, 7, 8};
        smp[1] = '{15, 0, 0, 0, 0, 0, 0, 0};
        smp[2] = '{-16, -16, -16, -16, -16, -16, -16, -16};
        smp[3] = '{-7, 13, -16, 15, 4, -9, 0, 11};

        // Reset with arbitrary sel
        cycle(1'b1, 3'd5);
        chk("reset yr", int'(yr[0]), 0);
        chk("reset yi", int'(yi[0]), 0);
        cycle(1'b1, 3'd2);
        cycle(1'b0, 3'd0);
        chk("release yr", int'(yr[0]), 36);
        chk("release yi", int'(yi[0]), 0);

        // Default samples, all bins; known literal results
        for (int k = 0; k < 8; k++) begin
            cycle(1'b0, 3'(k));
            chk($sformatf("default bin%0d re", k), int'(yr[0]), exp_re[k]);
            chk($sformatf("default bin%0d im", k), int'(yi[0]), exp_im[k]);
            chk($sformatf("impulse bin%0d re", k), int'(yr[1]), 15);
            chk($sformatf("impulse bin%0d im", k), int'(yi[1]), 0);
            chk($sformatf("extreme bin%0d re", k), int'(yr[2]), (k == 0) ? -128 : 0);
            chk($sformatf("extreme bin%0d im", k), int'(yi[2]), 0);
        end

        // Latency: output only moves on the edge that samples the new sel
        cycle(1'b0, 3'd1);
        sel = 3'd6;
        #2;
        chk("latency hold re", int'(yr[0]), -4);
        chk("latency hold im", int'(yi[0]), 10);
        cycle(1'b0, 3'd6);
        chk("latency new re", int'(yr[0]), -4);
        chk("latency new im", int'(yi[0]), -4);

        // Mid-run reset pulse
        cycle(1'b0, 3'd7);
        cycle(1'b1, 3'd7);
        chk("midrst yr", int'(yr[0]), 0);
        chk("midrst yi", int'(yi[0]), 0);
        cycle(1'b0, 3'd7);
        chk("resume yr", int'(yr[0]), -4);
        chk("resume yi", int'(yi[0]), -10);

        // Random sel with occasional reset
        for (int t = 0; t < 300; t++)
            cycle(($urandom_range(0, 15) == 0), 3'($urandom_range(0, 7)));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
